// File: rtl/ubvcska_share_arb.sv
// ubvcska_share_arb: round-robin arbiter that time-shares one 15+12-bit
// carry-skip adder among NREQ requesters and returns a registered,
// index-tagged 16-bit sum over a valid/ready handshake.
module ubvcska_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic [NREQ-1:0]    REQ,
    input  logic [15*NREQ-1:0] X,
    input  logic [12*NREQ-1:0] Y,
    output logic [NREQ-1:0]    GNT,
    output logic               VLD,
    output logic [15:0]        S,
    output logic [IDW-1:0]     ID,
    input  logic               RDY,
    output logic               BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_HOLD
    } state_t;

    // Carry-skip block boundaries: blocks [1:0], [4:2], [9:5], [12:10], [14:13].
    localparam logic [14:0] BLK_END = 15'b101_0010_0001_0010;

    state_t          state, state_nxt;
    logic [14:0]     ox;
    logic [11:0]     oy;
    logic [IDW-1:0]  tag;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_inc;
    logic            vld_q;
    logic [15:0]     s_q;
    logic [IDW-1:0]  id_q;

    logic            any_req;
    logic [IDW-1:0]  sel_idx;
    logic [IDW-1:0]  cand;
    logic [14:0]     sel_x;
    logic [11:0]     sel_y;
    logic [NREQ-1:0] gnt_raw;
    logic            do_grant;

    logic [14:0]     add_a, add_b;
    logic [15:0]     add_sum;
    logic            c, c_blk, p, p_blk;

    // Round-robin pick: first set REQ scanning ptr, ptr+1, ... modulo NREQ.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        any_req = 1'b0;
        sel_idx = '0;
        cand    = '0;
        // Scan from the far end so the candidate closest to ptr is the last write and wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (REQ[cand]) begin
                any_req = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Operand mux for the selected requester.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == IDW'(i)) begin
                sel_x = X[15*i +: 15];
                sel_y = Y[12*i +: 12];
            end
        end
    end

    assign ptr_inc = (int'(sel_idx) == NREQ - 1) ? '0 : sel_idx + 1'b1;

    // Next-state and grant decode; a grant is offered in IDLE or when HOLD is released.
    always_comb begin
        state_nxt = state;
        gnt_raw   = '0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt        = ST_EXEC;
                    gnt_raw[sel_idx] = 1'b1;
                end
            end
            ST_EXEC: state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (RDY) begin
                    if (any_req) begin
                        state_nxt        = ST_EXEC;
                        gnt_raw[sel_idx] = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign do_grant = |gnt_raw;
    assign GNT      = RSTn ? gnt_raw : '0;

    // Variable-block carry-skip adder: ripple inside a block, skip the block when all bits propagate.
    assign add_a = ox;
    assign add_b = {3'b000, oy};
    always_comb begin
        // NOTE: blocking assignments here model the carry rippling bit to bit within one evaluation.
        add_sum = '0;
        c       = 1'b0;
        c_blk   = 1'b0;
        p       = 1'b0;
        p_blk   = 1'b1;
        for (int i = 0; i < 15; i++) begin
            p          = add_a[i] ^ add_b[i];
            add_sum[i] = p ^ c;
            c          = (add_a[i] & add_b[i]) | (p & c);
            p_blk      = p_blk & p;
            if (BLK_END[i]) begin
                c     = p_blk ? c_blk : c;
                c_blk = c;
                p_blk = 1'b1;
            end
        end
        add_sum[15] = c;
    end

    // Control state, pointer and operand capture.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
            ptr   <= '0;
            ox    <= '0;
            oy    <= '0;
            tag   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking so all registers update from pre-edge values.
            state <= state_nxt;
            if (do_grant) begin
                ox  <= sel_x;
                oy  <= sel_y;
                tag <= sel_idx;
                ptr <= ptr_inc;
            end
        end
    end

    // Result registers: load on leaving EXEC, drop valid when the consumer takes it.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            vld_q <= 1'b0;
            s_q   <= '0;
            id_q  <= '0;
        end else if (state == ST_EXEC) begin
            vld_q <= 1'b1;
            s_q   <= add_sum;
            id_q  <= tag;
        end else if (state == ST_HOLD && RDY) begin
            vld_q <= 1'b0;
        end
    end

    assign VLD  = vld_q;
    assign S    = s_q;
    assign ID   = id_q;
    assign BUSY = (state != ST_IDLE);

endmodule
